// File: rtl/srm_ctrl_pkg.sv
// Shared definitions for the Simple RISC Machine multicycle controller:
// state encoding, instruction field codes, memory commands and the
// one-hot datapath select constants.
package srm_ctrl_pkg;

    localparam int SRM_STATE_W = 5;

    typedef enum logic [SRM_STATE_W-1:0] {
        S_RST   = 5'd0,
        S_IF1   = 5'd1,
        S_IF2   = 5'd2,
        S_UPC   = 5'd3,
        S_DEC   = 5'd4,
        S_WIMM  = 5'd5,
        S_GETA  = 5'd6,
        S_GETB  = 5'd7,
        S_ALU   = 5'd8,
        S_WREG  = 5'd9,
        S_ADDR  = 5'd10,
        S_LADDR = 5'd11,
        S_MRD   = 5'd12,
        S_MWB   = 5'd13,
        S_SGETB = 5'd14,
        S_SPASS = 5'd15,
        S_SWR   = 5'd16,
        S_HALT  = 5'd17,
        S_BR    = 5'd18
    } state_t;

    // instruction[15:13]
    localparam logic [2:0] OPC_BR   = 3'b001;
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    // instruction[12:11]
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    // instruction[10:8] branch conditions
    localparam logic [2:0] COND_AL = 3'b000;
    localparam logic [2:0] COND_EQ = 3'b001;
    localparam logic [2:0] COND_NE = 3'b010;
    localparam logic [2:0] COND_LT = 3'b011;
    localparam logic [2:0] COND_LE = 3'b100;

    // memory command
    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    // register-file read/write port select
    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b100;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b001;

    // writeback source select
    localparam logic [3:0] VSEL_NONE  = 4'b0000;
    localparam logic [3:0] VSEL_MDATA = 4'b1000;
    localparam logic [3:0] VSEL_IMM   = 4'b0100;
    localparam logic [3:0] VSEL_PC    = 4'b0010;
    localparam logic [3:0] VSEL_C     = 4'b0001;

    // Complete set of controller outputs, registered as one word
    typedef struct packed {
        logic [2:0] nsel;
        logic [3:0] vsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic       write;
        logic       load_ir;
        logic       load_pc;
        logic       reset_pc;
        logic       br_take;
        logic       addr_sel;
        logic       load_addr;
        logic [1:0] mem_cmd;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/srm_ctrl_fsm_br_cond.sv
// Branch condition evaluator: compares the instruction cond field with
// the {N,V,Z} status flags. Only present in builds with
// SRM_CTRL_BRANCH_EN defined; other builds have no branch hardware.
`ifdef SRM_CTRL_BRANCH_EN
module srm_br_cond
    import srm_ctrl_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] status,
    output logic       take
);

    logic flag_n;
    logic flag_v;
    logic flag_z;

    assign flag_n = status[2];
    assign flag_v = status[1];
    assign flag_z = status[0];

    // Signed comparisons use N!=V as "less than"; unknown codes never branch
    always_comb begin
        take = 1'b0;
        case (cond)
            COND_AL: take = 1'b1;
            COND_EQ: take = flag_z;
            COND_NE: take = ~flag_z;
            COND_LT: take = flag_n ^ flag_v;
            COND_LE: take = (flag_n ^ flag_v) | flag_z;
            default: take = 1'b0;
        endcase
    end

endmodule
`endif

// File: rtl/srm_ctrl_fsm.sv
// Multicycle Moore controller for the Simple RISC Machine datapath.
// Outputs are registered: each cycle the strobes for the state being
// entered are computed alongside the next state, so every output is a
// pure function of the current state and resets asynchronously.
// Build option: define SRM_CTRL_BRANCH_EN to enable conditional branches
// (opcode 001); without it opcode 001 halts and br_take stays 0.
// MEM_LAT (1..7) is the number of cycles a memory READ is held before the
// data is captured.
module srm_ctrl_fsm
    import srm_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int STATE_W = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    input  logic [2:0] cond,
    input  logic [2:0] status,
    output logic [2:0] nsel,
    output logic [3:0] vsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic       write,
    output logic       load_ir,
    output logic       load_pc,
    output logic       reset_pc,
    output logic       br_take,
    output logic       addr_sel,
    output logic       load_addr,
    output logic [1:0] mem_cmd,
    output logic       halted
);

    localparam int              CNT_W     = 3;
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(MEM_LAT - 1);

    logic [STATE_W-1:0] state_q;
    logic [CNT_W-1:0]   wait_cnt;
    ctrl_t              ctrl_q;
    state_t             cur;
    state_t             nxt;
    logic               wait_done;
    logic               wait_load;
    logic               take;

    assign cur       = state_t'(state_q[SRM_STATE_W-1:0]);
    assign wait_done = (wait_cnt == '0);

    // The latency counter is reloaded whenever a memory-read wait state is
    // freshly entered, so back-to-back fetches each get the full latency.
    assign wait_load = ((nxt == S_IF1) && (cur != S_IF1)) ||
                       ((nxt == S_MRD) && (cur != S_MRD));

`ifdef SRM_CTRL_BRANCH_EN
    srm_br_cond u_br_cond (
        .cond   (cond),
        .status (status),
        .take   (take)
    );
`else
    logic unused_br;
    assign unused_br = ^{cond, status};
    assign take      = 1'b0;
`endif

    function automatic state_t next_state(
        input state_t     s,
        input logic [2:0] opc,
        input logic [1:0] o,
        input logic       done
    );
        state_t n;
        n = S_RST;
        case (s)
            S_RST:   n = S_IF1;
            S_IF1:   n = done ? S_IF2 : S_IF1;
            S_IF2:   n = S_UPC;
            S_UPC:   n = S_DEC;
            S_DEC: begin
                case (opc)
                    OPC_MOV: begin
                        if (o == OP_MOV_IMM)      n = S_WIMM;
                        else if (o == OP_MOV_REG) n = S_GETB;
                        else                      n = S_HALT;
                    end
                    OPC_ALU:  n = (o == OP_MVN) ? S_GETB : S_GETA;
                    OPC_LDR,
                    OPC_STR:  n = S_GETA;
`ifdef SRM_CTRL_BRANCH_EN
                    OPC_BR:   n = S_BR;
`endif
                    OPC_HALT: n = S_HALT;
                    default:  n = S_HALT;
                endcase
            end
            S_WIMM:  n = S_IF1;
            S_GETA:  n = ((opc == OPC_LDR) || (opc == OPC_STR)) ? S_ADDR : S_GETB;
            S_GETB:  n = S_ALU;
            S_ALU:   n = ((opc == OPC_ALU) && (o == OP_CMP)) ? S_IF1 : S_WREG;
            S_WREG:  n = S_IF1;
            S_ADDR:  n = S_LADDR;
            S_LADDR: n = (opc == OPC_LDR) ? S_MRD : S_SGETB;
            S_MRD:   n = done ? S_MWB : S_MRD;
            S_MWB:   n = S_IF1;
            S_SGETB: n = S_SPASS;
            S_SPASS: n = S_SWR;
            S_SWR:   n = S_IF1;
            S_HALT:  n = S_HALT;
            S_BR:    n = S_IF1;
            default: n = S_RST;
        endcase
        return n;
    endfunction

    function automatic ctrl_t ctrl_of(
        input state_t     s,
        input logic [2:0] opc,
        input logic [1:0] o,
        input logic       br
    );
        ctrl_t c;
        c = '0;
        case (s)
            S_RST: begin
                c.reset_pc = 1'b1;
                c.load_pc  = 1'b1;
            end
            S_IF1: begin
                c.addr_sel = 1'b1;
                c.mem_cmd  = MEM_READ;
            end
            S_IF2: begin
                c.addr_sel = 1'b1;
                c.mem_cmd  = MEM_READ;
                c.load_ir  = 1'b1;
            end
            S_UPC:   c.load_pc = 1'b1;
            S_WIMM: begin
                c.nsel  = NSEL_RN;
                c.vsel  = VSEL_IMM;
                c.write = 1'b1;
            end
            S_GETA: begin
                c.nsel  = NSEL_RN;
                c.loada = 1'b1;
            end
            S_GETB: begin
                c.nsel  = NSEL_RM;
                c.loadb = 1'b1;
            end
            S_ALU: begin
                // MOV Rd,Rm and MVN pass B through with A forced to zero
                c.asel = (opc == OPC_MOV) || ((opc == OPC_ALU) && (o == OP_MVN));
                if ((opc == OPC_ALU) && (o == OP_CMP)) c.loads = 1'b1;
                else                                  c.loadc = 1'b1;
            end
            S_WREG: begin
                c.nsel  = NSEL_RD;
                c.vsel  = VSEL_C;
                c.write = 1'b1;
            end
            S_ADDR: begin
                c.bsel  = 1'b1;
                c.loadc = 1'b1;
            end
            S_LADDR: c.load_addr = 1'b1;
            S_MRD:   c.mem_cmd   = MEM_READ;
            S_MWB: begin
                c.mem_cmd = MEM_READ;
                c.nsel    = NSEL_RD;
                c.vsel    = VSEL_MDATA;
                c.write   = 1'b1;
            end
            S_SGETB: begin
                c.nsel  = NSEL_RD;
                c.loadb = 1'b1;
            end
            S_SPASS: begin
                c.asel  = 1'b1;
                c.loadc = 1'b1;
            end
            S_SWR:   c.mem_cmd = MEM_WRITE;
            S_HALT:  c.halted  = 1'b1;
            S_BR: begin
                c.load_pc = br;
                c.br_take = br;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    assign nxt = next_state(cur, opcode, op, wait_done);

    // State, latency counter and the output word for the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= STATE_W'(S_RST);
            wait_cnt <= '0;
            ctrl_q   <= ctrl_of(S_RST, OPC_HALT, OP_ADD, 1'b0);
        end else begin
            state_q <= STATE_W'(nxt);
            if (wait_load)
                wait_cnt <= WAIT_INIT;
            else if (!wait_done)
                wait_cnt <= wait_cnt - CNT_W'(1);
            ctrl_q <= ctrl_of(nxt, opcode, op, take);
        end
    end

    assign nsel      = ctrl_q.nsel;
    assign vsel      = ctrl_q.vsel;
    assign loada     = ctrl_q.loada;
    assign loadb     = ctrl_q.loadb;
    assign loadc     = ctrl_q.loadc;
    assign loads     = ctrl_q.loads;
    assign asel      = ctrl_q.asel;
    assign bsel      = ctrl_q.bsel;
    assign write     = ctrl_q.write;
    assign load_ir   = ctrl_q.load_ir;
    assign load_pc   = ctrl_q.load_pc;
    assign reset_pc  = ctrl_q.reset_pc;
    assign br_take   = ctrl_q.br_take;
    assign addr_sel  = ctrl_q.addr_sel;
    assign load_addr = ctrl_q.load_addr;
    assign mem_cmd   = ctrl_q.mem_cmd;
    assign halted    = ctrl_q.halted;

endmodule

// File: doc/srm_ctrl_fsm.md
Name: srm_ctrl_fsm

Overview:
Multicycle Moore controller for the Simple RISC Machine datapath. It sequences fetch, PC update, decode, register read/write, ALU, load/store and (optionally) branch for each instruction. Its inputs are the decoded fields (opcode, op, cond) and the status flags. Its outputs are the datapath strobes (nsel, vsel, load enables, mux selects, write) and the memory command.

Parameters:
MEM_LAT, 1, cycles mem_cmd=READ is held before data is captured (fetch and LDR); legal range 1..7.
STATE_W, 5, state register width.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
opcode  in  3  instruction [15:13]
op  in  2  instruction [12:11]
cond  in  3  instruction [10:8]
status  in  3  {N,V,Z} from status register
nsel  out  3  one-hot register select: [2]=Rn, [1]=Rd, [0]=Rm
vsel  out  4  one-hot writeback source: [3]=mdata, [2]=sximm8, [1]=PC, [0]=C
loada, loadb, loadc, loads  out  1 each  datapath register enables
asel  out  1  1 = A operand forced to 0
bsel  out  1  1 = B operand is sximm5
write  out  1  register-file write enable
load_ir, load_pc, reset_pc, br_take  out  1 each  IR/PC control; br_take selects PC+sximm8
addr_sel  out  1  1 = memory address from PC, 0 = from data-address register
load_addr  out  1  data-address register enable
mem_cmd  out  2  NONE=00, READ=01, WRITE=10
halted  out  1  high in S_HALT

Behaviour:
- rst_n low forces state to S_RST asynchronously. Outputs are a pure function of state. Every output not listed for a state is 0 (nsel=000, vsel=0000, mem_cmd=NONE).
- S_RST: reset_pc=1, load_pc=1 -> S_IF1.
- S_IF1: addr_sel=1, mem_cmd=READ. The wait counter loads MEM_LAT-1 on entry. Stay while the counter is nonzero, decrementing each cycle; then -> S_IF2.
- S_IF2: addr_sel=1, mem_cmd=READ, load_ir=1 -> S_UPC.
- S_UPC: load_pc=1 -> S_DEC.
- S_DEC (no strobes) dispatches:
  - 110/10 -> S_WIMM
  - 110/00 or 101/11 -> S_GETB
  - 101/other -> S_GETA
  - 011, 100 -> S_GETA
  - 001 -> S_BR (feature on only)
  - 111 and all other codes -> S_HALT
- S_WIMM: nsel=100, vsel=0100, write -> S_IF1.
- S_GETA: nsel=100, loada. Next state: ALU ops -> S_GETB; LDR/STR -> S_ADDR.
- S_GETB: nsel=001, loadb -> S_ALU.
- S_ALU: asel=1 for MOV/MVN. CMP asserts loads only, then -> S_IF1. All others assert loadc, then -> S_WREG.
- S_WREG: nsel=010, vsel=0001, write -> S_IF1.
- S_ADDR: bsel=1, loadc -> S_LADDR.
- S_LADDR: load_addr. Next: LDR -> S_MRD; STR -> S_SGETB.
- S_MRD: mem_cmd=READ, addr_sel=0, MEM_LAT wait as in S_IF1 -> S_MWB.
- S_MWB: mem_cmd=READ, nsel=010, vsel=1000, write -> S_IF1.
- S_SGETB: nsel=010, loadb -> S_SPASS.
- S_SPASS: asel=1, loadc -> S_SWR.
- S_SWR: mem_cmd=WRITE, addr_sel=0 -> S_IF1.
- S_HALT: halted=1; absorbing until rst_n low.
- opcode/op are sampled only in S_DEC and during execute states. They are stable because IR loads only in S_IF2.
- Reset mid-instruction: abandon immediately, no partial write. Unused state encodings -> S_RST.

Optional Feature:
Macro SRM_CTRL_BRANCH_EN.
- Defined: S_BR evaluates cond against status.
  - 000 always
  - 001 Z
  - 010 !Z
  - 011 N!=V
  - 100 (N!=V)|Z
  - others never
  - Taken: load_pc=1, br_take=1. Both outcomes -> S_IF1.
- Undefined: S_BR is absent, br_take is tied 0, opcode 001 -> S_HALT.

Decomposition:
Package srm_ctrl_pkg holds:
- state enum
- opcode/op localparams (MOV, ALU, LDR, STR, HALT, BR)
- mem_cmd encodings
- nsel and vsel one-hot constants

One combinational sub-module, srm_br_cond (cond, status -> take), is instantiated only under SRM_CTRL_BRANCH_EN.

Test Plan:
- Release rst_n, MEM_LAT=1: S_RST (reset_pc=1, load_pc=1) -> IF1 -> IF2 (load_ir=1) -> UPC (load_pc=1) -> DEC, one cycle each.
- MOV R3,#-5 (110/10): after S_DEC, one cycle nsel=100, vsel=0100, write=1; next cycle mem_cmd=READ, addr_sel=1.
- ADD (101/00) -> loada(nsel=100), loadb(nsel=001), loadc, write(nsel=010, vsel=0001). CMP (101/01): loads=1, loadc=0, no write.
- LDR with MEM_LAT=3: S_MRD holds mem_cmd=READ for 3 cycles, then write=1 with vsel=1000. STR: mem_cmd=WRITE for exactly 1 cycle, write never asserted.
- Opcode 111: halted=1 held for 20 cycles with no strobes. Pull rst_n low mid-S_ALU: outputs immediately go to S_RST values.
- With SRM_CTRL_BRANCH_EN, cond=011:
  - status N=1,V=0 -> br_take=1, load_pc=1.
  - status N=1,V=1 -> br_take=0, load_pc=0.
  - Without the macro, opcode 001 -> halted=1.
